muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Scheduler that shares one iterative multiplier and one iterative divider between the two execute-stage ALU lanes of the dual-issue pipeline.
- Accepts requests from lane 1 (older) and lane 2 in the same bundle and serialises them, lane 1 first.
- Sequences the unit start/ready handshake and stalls the execute stage until every request in the bundle has finished.
- Forms the HI/LO write value, including accumulate ops and lane-1-to-lane-2 HI/LO forwarding, and commits it once per bundle.

Parameters:
- W, 32, operand width; products, quotients and the HI/LO value are 2*W wide.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req1, req2  in  1  lane has a mul/div op this cycle
- op1, op2  in  3  000 MULT, 001 DIV, 010 MUL (GPR result, no HI/LO write), 011 MADD, 100 MSUB; others = no-op
- sgn1, sgn2  in  1  1 = signed
- a1, b1, a2, b2  in  W  lane operands
- hilo_cur  in  2W  current HI/LO register value
- stall_masterE  in  1  execute stage held by another source
- flush_masterE  in  1  kill the execute-stage bundle
- flush_exception_masterM  in  1  suppresses the HI/LO commit
- unit_mul_start, unit_div_start  out  1  start to the multiplier / divider
- unit_sign  out  1  signedness of the active op
- unit_a, unit_b  out  W  latched operands of the active op
- unit_flush  out  1  equals flush_masterE
- mul_ready, div_ready  in  1  one-cycle completion pulses
- mul_res, div_res  in  2W  unit results
- md_stall  out  1  execute-stage stall request
- gpr_out1, gpr_out2  out  W  low W bits of the MUL product per lane
- hilo_we  out  1  HI/LO write enable
- hilo_wdata  out  2W  HI/LO write data

Behaviour:
- States: IDLE, RUN1, RUN2, DONE.
- Reset (rst low, asynchronous): state IDLE; every output 0; pending flags, latched operands, gpr_out*, accumulator cleared.
- A lane is valid when its req is high and its op is not a no-op.
- IDLE:
  - Lane 1 valid: latch lane-1 op/operands, go to RUN1. Lane 2 valid: set pend2.
  - Only lane 2 valid: latch lane 2, go to RUN2.
  - Neither valid: stay in IDLE.
  - Latching also loads acc <= hilo_cur.
- RUN1/RUN2:
  - unit_*_start = state is RUN and the op selects that unit and the matching ready is low. DIV uses the divider; all other ops use the multiplier.
  - unit_start therefore drops in the cycle ready is seen; at least one idle cycle precedes a new start.
  - On ready, update acc: MULT/DIV acc <= res; MADD acc <= acc + res; MSUB acc <= acc - res; MUL: gpr_outN <= res[W-1:0], acc unchanged.
  - Set hw_dirty if the op is not MUL.
  - In RUN1 on ready: go to RUN2 if pend2, latching lane 2 (lane-2 accumulate sees lane 1's updated acc); otherwise go to DONE.
  - In RUN2 on ready: go to DONE.
- md_stall = (IDLE and any lane valid) or RUN1 or RUN2. Low in DONE.
- DONE:
  - If stall_masterE is high: hold all results, stay in DONE, accept no requests.
  - Otherwise, in this cycle: hilo_we = hw_dirty and not flush_exception_masterM; hilo_wdata = acc. Then go to IDLE and clear hw_dirty and pend2.
  - Exactly one HI/LO write per bundle.
- flush_masterE:
  - Dominant in any state: next state IDLE, pending flags and hw_dirty cleared, hilo_we forced 0.
  - unit_flush aborts the units; a ready arriving in the same cycle is ignored.
- gpr_out1/gpr_out2 remain valid from completion until the next latch in IDLE.
- Arithmetic is modulo 2^(2W). Division by zero passes through the divider result unchanged.

Test Plan:
- Lane-1 MULT only, a1=0xFFFFFFFE, b1=3, signed -> one mul start, md_stall until ready, hilo_we one cycle with hilo_wdata=0xFFFFFFFF_FFFFFFFA.
- Lane-1 DIVU 100/7 plus lane-2 MUL 6*7 in the same bundle -> divider runs first, then multiplier with a gap cycle between starts; gpr_out2=42; hilo_wdata = divider result (rem 2, quot 14); single hilo_we.
- Lane-1 MULT 2*3 plus lane-2 MADD 4*5, hilo_cur=100 -> hilo_wdata=26 (forwarded acc, not 120).
- stall_masterE held high 3 cycles in DONE -> md_stall low, no hilo_we until stall_masterE falls, then exactly one pulse.
- flush_masterE during RUN1 with lane 2 pending -> unit_flush high, IDLE next cycle, no RUN2, no hilo_we.
- Lane-1 MSUB with flush_exception_masterM high at commit -> hilo_we=0. Also: rst low mid-RUN2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// Bundle, unit and HI/LO signals of the mul/div scheduler, plus a debug view of its FSM state.
// Handshake: a *_start level is held until the matching one-cycle *_ready pulse; the unit accepts a start only when idle.
interface muldiv_sched_if #(
   parameter int W = 32
);
   logic             req1, req2;
   logic [2:0]       op1, op2;
   logic             sgn1, sgn2;
   logic [W-1:0]     a1, b1, a2, b2;
   logic [2*W-1:0]   hilo_cur;
   logic             stall_masterE;
   logic             flush_masterE;
   logic             flush_exception_masterM;
   logic             unit_mul_start, unit_div_start;
   logic             unit_sign;
   logic [W-1:0]     unit_a, unit_b;
   logic             unit_flush;
   logic             mul_ready, div_ready;
   logic [2*W-1:0]   mul_res, div_res;
   logic             md_stall;
   logic [W-1:0]     gpr_out1, gpr_out2;
   logic             hilo_we;
   logic [2*W-1:0]   hilo_wdata;
   logic [1:0]       dbg_state;

   modport slave (
      input  req1, req2, op1, op2, sgn1, sgn2, a1, b1, a2, b2, hilo_cur,
      input  stall_masterE, flush_masterE, flush_exception_masterM,
      input  mul_ready, div_ready, mul_res, div_res,
      output unit_mul_start, unit_div_start, unit_sign, unit_a, unit_b, unit_flush,
      output md_stall, gpr_out1, gpr_out2, hilo_we, hilo_wdata, dbg_state
   );

   modport master (
      output req1, req2, op1, op2, sgn1, sgn2, a1, b1, a2, b2, hilo_cur,
      output stall_masterE, flush_masterE, flush_exception_masterM,
      output mul_ready, div_ready, mul_res, div_res,
      input  unit_mul_start, unit_div_start, unit_sign, unit_a, unit_b, unit_flush,
      input  md_stall, gpr_out1, gpr_out2, hilo_we, hilo_wdata, dbg_state
   );
endinterface

// File: rtl/muldiv_sched.sv
// Serialises the two execute-lane mul/div requests onto one multiplier and one divider,
// accumulates the HI/LO value across the bundle and commits it once.
module muldiv_sched #(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN1 = 2'd1, RUN2 = 2'd2, DONE = 2'd3} state_t;

   localparam logic [2:0] OP_MULT = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_MADD = 3'd3;
   localparam logic [2:0] OP_MSUB = 3'd4;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic           sgn_q, sgn_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic           pend2_q, pend2_d;
   logic           dirty_q, dirty_d;
   logic [W-1:0]   gpr1_q, gpr1_d, gpr2_q, gpr2_d;

   logic           v1, v2, is_div, in_run, unit_ready, hilo_we;
   logic [2*W-1:0] res;

   assign v1         = bus.req1 && (bus.op1 <= OP_MSUB);
   assign v2         = bus.req2 && (bus.op2 <= OP_MSUB);
   assign is_div     = (op_q == OP_DIV);
   assign in_run     = (state_q == RUN1) || (state_q == RUN2);
   assign unit_ready = is_div ? bus.div_ready : bus.mul_ready;
   assign res        = is_div ? bus.div_res : bus.mul_res;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      pend2_d = pend2_q;
      dirty_d = dirty_q;
      gpr1_d  = gpr1_q;
      gpr2_d  = gpr2_q;
      hilo_we = 1'b0;

      case (state_q)
         IDLE: begin
            if (v1) begin
               op_d    = bus.op1;
               sgn_d   = bus.sgn1;
               a_d     = bus.a1;
               b_d     = bus.b1;
               acc_d   = bus.hilo_cur;
               pend2_d = v2;
               state_d = RUN1;
            end else if (v2) begin
               op_d    = bus.op2;
               sgn_d   = bus.sgn2;
               a_d     = bus.a2;
               b_d     = bus.b2;
               acc_d   = bus.hilo_cur;
               state_d = RUN2;
            end
         end
         RUN1, RUN2: begin
            if (unit_ready) begin
               case (op_q)
                  OP_MULT, OP_DIV: acc_d = res;
                  OP_MADD:         acc_d = acc_q + res;
                  OP_MSUB:         acc_d = acc_q - res;
                  default: begin
                     if (state_q == RUN1) gpr1_d = res[W-1:0];
                     else                 gpr2_d = res[W-1:0];
                  end
               endcase
               if (op_q != OP_MUL) dirty_d = 1'b1;
               // Lane 2 is still held in execute by md_stall, so its operands are read live here.
               if (state_q == RUN1 && pend2_q) begin
                  op_d    = bus.op2;
                  sgn_d   = bus.sgn2;
                  a_d     = bus.a2;
                  b_d     = bus.b2;
                  state_d = RUN2;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!bus.stall_masterE) begin
               hilo_we = dirty_q && !bus.flush_exception_masterM;
               dirty_d = 1'b0;
               pend2_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush kills the bundle outright, including any completion arriving this cycle.
      if (bus.flush_masterE) begin
         state_d = IDLE;
         pend2_d = 1'b0;
         dirty_d = 1'b0;
         acc_d   = acc_q;
         gpr1_d  = gpr1_q;
         gpr2_d  = gpr2_q;
         hilo_we = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         sgn_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         pend2_q <= 1'b0;
         dirty_q <= 1'b0;
         gpr1_q  <= '0;
         gpr2_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sgn_q   <= sgn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         pend2_q <= pend2_d;
         dirty_q <= dirty_d;
         gpr1_q  <= gpr1_d;
         gpr2_q  <= gpr2_d;
      end
   end

   assign bus.unit_mul_start = in_run && !is_div && !bus.mul_ready;
   assign bus.unit_div_start = in_run && is_div && !bus.div_ready;
   assign bus.unit_sign      = sgn_q;
   assign bus.unit_a         = a_q;
   assign bus.unit_b         = b_q;
   assign bus.unit_flush     = bus.flush_masterE;
   assign bus.md_stall       = ((state_q == IDLE) && (v1 || v2)) || in_run;
   assign bus.gpr_out1       = gpr1_q;
   assign bus.gpr_out2       = gpr2_q;
   assign bus.hilo_we        = hilo_we;
   assign bus.hilo_wdata     = acc_q;
   assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: behavioural multiplier/divider, HI/LO commit queue, scenario tasks.
module tb_muldiv_sched;
   localparam int W = 32;
   localparam logic [2:0] OP_MULT = 3'd0, OP_DIV = 3'd1, OP_MUL = 3'd2, OP_MADD = 3'd3, OP_MSUB = 3'd4;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN1 = 2'd1, S_RUN2 = 2'd2, S_DONE = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   muldiv_sched_if #(.W(W)) mif ();
   muldiv_sched #(.W(W)) dut (.clk(clk), .rst(rst), .bus(mif));

   int checks = 0, errors = 0, we_count = 0, cyc = 0;
   int mul_starts = 0, div_starts = 0, gap_err = 0, mul_rise_cyc = 0, div_rise_cyc = 0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] exp_v;
   logic prev_mul = 1'b0, prev_div = 1'b0;

   function automatic logic [63:0] ref_res(input logic [2:0] op, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ae, be;
      int sa, sb;
      if (op == OP_DIV) begin
         if (b == 32'd0) return {a, 32'hFFFF_FFFF};
         if (s) begin
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
         end
         return {a % b, a / b};
      end
      ae = s ? {{32{a[31]}}, a} : {32'd0, a};
      be = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ae * be;
   endfunction

   // behavioural multiplier and divider
   logic mul_busy, div_busy;
   int mul_cnt, div_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_busy <= 1'b0; mul_cnt <= 0; mif.mul_ready <= 1'b0; mif.mul_res <= '0;
      end else if (mif.unit_flush) begin
         mul_busy <= 1'b0; mif.mul_ready <= 1'b0;
      end else if (mif.mul_ready) begin
         mif.mul_ready <= 1'b0;
      end else if (!mul_busy && mif.unit_mul_start) begin
         mul_busy <= 1'b1;
         mul_cnt  <= $urandom_range(1, 4);
         mif.mul_res <= ref_res(OP_MULT, mif.unit_sign, mif.unit_a, mif.unit_b);
      end else if (mul_busy) begin
         if (mul_cnt <= 1) begin mul_busy <= 1'b0; mif.mul_ready <= 1'b1; end
         else mul_cnt <= mul_cnt - 1;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_busy <= 1'b0; div_cnt <= 0; mif.div_ready <= 1'b0; mif.div_res <= '0;
      end else if (mif.unit_flush) begin
         div_busy <= 1'b0; mif.div_ready <= 1'b0;
      end else if (mif.div_ready) begin
         mif.div_ready <= 1'b0;
      end else if (!div_busy && mif.unit_div_start) begin
         div_busy <= 1'b1;
         div_cnt  <= $urandom_range(1, 4);
         mif.div_res <= ref_res(OP_DIV, mif.unit_sign, mif.unit_a, mif.unit_b);
      end else if (div_busy) begin
         if (div_cnt <= 1) begin div_busy <= 1'b0; mif.div_ready <= 1'b1; end
         else div_cnt <= div_cnt - 1;
      end
   end

   // monitor: start edges, start gap and HI/LO commit scoreboard
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (mif.unit_mul_start && !prev_mul) begin mul_starts++; mul_rise_cyc = cyc; end
         if (mif.unit_div_start && !prev_div) begin div_starts++; div_rise_cyc = cyc; end
         if ((mif.unit_mul_start && prev_div) || (mif.unit_div_start && prev_mul)) gap_err++;
         prev_mul = mif.unit_mul_start;
         prev_div = mif.unit_div_start;
         if (mif.hilo_we) begin
            we_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL hilo_commit unexpected write got %h exp none", mif.hilo_wdata);
            end else begin
               exp_v = exp_q.pop_front();
               if (mif.hilo_wdata !== exp_v) begin
                  errors++;
                  $display("FAIL hilo_commit got %h exp %h", mif.hilo_wdata, exp_v);
               end
            end
         end
      end else begin
         prev_mul = 1'b0;
         prev_div = 1'b0;
      end
   end

   task automatic clear_inputs();
      mif.req1 = 0; mif.req2 = 0; mif.op1 = 0; mif.op2 = 0; mif.sgn1 = 0; mif.sgn2 = 0;
      mif.a1 = 0; mif.b1 = 0; mif.a2 = 0; mif.b2 = 0; mif.hilo_cur = 0;
      mif.stall_masterE = 0; mif.flush_masterE = 0; mif.flush_exception_masterM = 0;
   endtask

   task automatic drive(input logic r1, input logic [2:0] o1, input logic s1, input logic [31:0] x1,
                        input logic [31:0] y1, input logic r2, input logic [2:0] o2, input logic s2,
                        input logic [31:0] x2, input logic [31:0] y2, input logic [63:0] hc);
      mif.req1 = r1; mif.op1 = o1; mif.sgn1 = s1; mif.a1 = x1; mif.b1 = y1;
      mif.req2 = r2; mif.op2 = o2; mif.sgn2 = s2; mif.a2 = x2; mif.b2 = y2;
      mif.hilo_cur = hc;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      bit seen = 0;
      while (n < 300 && !seen) begin
         @(negedge clk);
         n++;
         if (mif.dbg_state == S_DONE && !mif.stall_masterE) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL %s_timeout got no DONE exp DONE within 300 cycles", name); end
      @(posedge clk); #1;
      mif.req1 = 0; mif.req2 = 0;
   endtask

   task automatic wait_state(input logic [1:0] st, input string name);
      int n = 0;
      while (n < 300 && mif.dbg_state != st) begin @(negedge clk); n++; end
      checks++;
      if (mif.dbg_state != st) begin errors++; $display("FAIL %s_timeout got %0d exp %0d", name, mif.dbg_state, st); end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mif.md_stall !== 1'b0) begin errors++; $display("FAIL reset_md_stall got %b exp 0", mif.md_stall); end
      checks++; if (mif.hilo_we !== 1'b0) begin errors++; $display("FAIL reset_hilo_we got %b exp 0", mif.hilo_we); end
      checks++; if (mif.hilo_wdata !== 64'd0) begin errors++; $display("FAIL reset_hilo_wdata got %h exp 0", mif.hilo_wdata); end
      checks++; if (mif.dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", mif.dbg_state); end
      checks++; if ({mif.unit_mul_start, mif.unit_div_start, mif.unit_a} !== 34'd0) begin
         errors++; $display("FAIL reset_unit got %h exp 0", {mif.unit_mul_start, mif.unit_div_start, mif.unit_a}); end
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult_single();
      int m0 = mul_starts, d0 = div_starts, w0 = we_count;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
      drive(1, OP_MULT, 1, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 0, 0, 0, 64'd0);
      @(negedge clk);
      checks++; if (mif.md_stall !== 1'b1) begin errors++; $display("FAIL mult_stall_idle got %b exp 1", mif.md_stall); end
      @(negedge clk);
      checks++; if (mif.md_stall !== 1'b1 || mif.dbg_state !== S_RUN1) begin
         errors++; $display("FAIL mult_stall_run got %b/%0d exp 1/1", mif.md_stall, mif.dbg_state); end
      wait_done("mult");
      checks++; if (mul_starts - m0 !== 1) begin errors++; $display("FAIL mult_starts got %0d exp 1", mul_starts - m0); end
      checks++; if (div_starts - d0 !== 0) begin errors++; $display("FAIL mult_div_starts got %0d exp 0", div_starts - d0); end
      checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL mult_we_count got %0d exp 1", we_count - w0); end
   endtask

   task automatic test_div_mul();
      int m0 = mul_starts, d0 = div_starts, w0 = we_count, g0 = gap_err;
      exp_q.push_back({32'd2, 32'd14});
      drive(1, OP_DIV, 0, 32'd100, 32'd7, 1, OP_MUL, 0, 32'd6, 32'd7, 64'd0);
      wait_done("divmul");
      checks++; if (mif.gpr_out2 !== 32'd42) begin errors++; $display("FAIL divmul_gpr2 got %0d exp 42", mif.gpr_out2); end
      checks++; if (mul_starts - m0 !== 1 || div_starts - d0 !== 1 || !(div_rise_cyc < mul_rise_cyc)) begin
         errors++; $display("FAIL divmul_order got div@%0d mul@%0d exp div first", div_rise_cyc, mul_rise_cyc); end
      checks++; if (gap_err !== g0) begin errors++; $display("FAIL divmul_gap got %0d exp %0d", gap_err, g0); end
      checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL divmul_we_count got %0d exp 1", we_count - w0); end
   endtask

   task automatic test_madd_fwd();
      int w0 = we_count;
      exp_q.push_back(64'd26);
      drive(1, OP_MULT, 0, 32'd2, 32'd3, 1, OP_MADD, 0, 32'd4, 32'd5, 64'd100);
      wait_done("madd");
      checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL madd_we_count got %0d exp 1", we_count - w0); end
   endtask

   task automatic test_stall_done();
      int w0 = we_count;
      mif.stall_masterE = 1;
      exp_q.push_back(64'd25);
      drive(1, OP_MULT, 0, 32'd5, 32'd5, 0, 3'd0, 0, 0, 0, 64'd0);
      wait_state(S_DONE, "stall");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if (mif.md_stall !== 1'b0 || we_count !== w0 || mif.dbg_state !== S_DONE) begin
            errors++; $display("FAIL stall_hold got stall=%b we=%0d st=%0d exp 0/%0d/3", mif.md_stall, we_count, mif.dbg_state, w0); end
      end
      @(posedge clk); #1;
      mif.stall_masterE = 0; mif.req1 = 0;
      @(posedge clk); #1;
      checks++; if (we_count - w0 !== 1 || mif.dbg_state !== S_IDLE) begin
         errors++; $display("FAIL stall_release got we=%0d st=%0d exp 1/0", we_count - w0, mif.dbg_state); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL stall_single got %0d exp 1", we_count - w0); end
   endtask

   task automatic test_flush();
      int w0 = we_count;
      bit saw_run2 = 0;
      drive(1, OP_MULT, 0, 32'd9, 32'd9, 1, OP_MUL, 0, 32'd2, 32'd2, 64'd0);
      wait_state(S_RUN1, "flush");
      mif.flush_masterE = 1; mif.req1 = 0; mif.req2 = 0;
      #1;
      checks++; if (mif.unit_flush !== 1'b1) begin errors++; $display("FAIL flush_unit got %b exp 1", mif.unit_flush); end
      @(posedge clk); #1;
      mif.flush_masterE = 0;
      checks++; if (mif.dbg_state !== S_IDLE) begin errors++; $display("FAIL flush_idle got %0d exp 0", mif.dbg_state); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mif.dbg_state == S_RUN2) saw_run2 = 1;
      end
      #1;
      checks++; if (saw_run2 !== 1'b0) begin errors++; $display("FAIL flush_no_run2 got %b exp 0", saw_run2); end
      checks++; if (we_count !== w0) begin errors++; $display("FAIL flush_no_we got %0d exp %0d", we_count, w0); end
      @(posedge clk); #1;
   endtask

   task automatic test_msub_exc();
      int w0 = we_count;
      mif.flush_exception_masterM = 1;
      drive(1, OP_MSUB, 0, 32'd3, 32'd4, 0, 3'd0, 0, 0, 0, 64'd100);
      wait_done("msub_exc");
      mif.flush_exception_masterM = 0;
      checks++; if (we_count !== w0) begin errors++; $display("FAIL msub_exc_we got %0d exp %0d", we_count, w0); end
      exp_q.push_back(64'd88);
      drive(1, OP_MSUB, 1, 32'd3, 32'd4, 0, 3'd0, 0, 0, 0, 64'd100);
      wait_done("msub");
      checks++; if (we_count - w0 !== 1) begin errors++; $display("FAIL msub_we got %0d exp 1", we_count - w0); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         logic r1, r2, s1, s2, v1, v2, dirty, m1, m2;
         logic [2:0] o1, o2;
         logic [31:0] x1, y1, x2, y2, g1, g2;
         logic [63:0] hc, acc, res;
         int w0 = we_count;
         r1 = ($urandom_range(0, 3) != 0); o1 = 3'($urandom_range(0, 5)); s1 = 1'($urandom_range(0, 1));
         r2 = ($urandom_range(0, 2) != 0); o2 = 3'($urandom_range(0, 6)); s2 = 1'($urandom_range(0, 1));
         x1 = $urandom; y1 = $urandom_range(1, 1000); x2 = $urandom; y2 = $urandom_range(1, 1000);
         if (s1 && $urandom_range(0, 1) == 1) y1 = -y1;
         if (s2 && $urandom_range(0, 1) == 1) y2 = -y2;
         if (x1 == 32'h8000_0000) x1 = 32'd1;
         if (x2 == 32'h8000_0000) x2 = 32'd1;
         hc = {$urandom, $urandom};
         v1 = r1 && (o1 <= OP_MSUB); v2 = r2 && (o2 <= OP_MSUB);
         if (!v1 && !v2) begin r1 = 1; o1 = OP_MADD; v1 = 1; end
         acc = hc; dirty = 0; m1 = 0; m2 = 0; g1 = 0; g2 = 0;
         for (int l = 0; l < 2; l++) begin
            logic [2:0] o;
            if ((l == 0 && v1) || (l == 1 && v2)) begin
               o = (l == 0) ? o1 : o2;
               res = (l == 0) ? ref_res(o1, s1, x1, y1) : ref_res(o2, s2, x2, y2);
               case (o)
                  OP_MULT, OP_DIV: acc = res;
                  OP_MADD: acc = acc + res;
                  OP_MSUB: acc = acc - res;
                  default: if (l == 0) begin m1 = 1; g1 = res[31:0]; end else begin m2 = 1; g2 = res[31:0]; end
               endcase
               if (o != OP_MUL) dirty = 1;
            end
         end
         if (dirty) exp_q.push_back(acc);
         drive(r1, o1, s1, x1, y1, r2, o2, s2, x2, y2, hc);
         wait_done("b2b");
         checks++; if (we_count - w0 !== int'(dirty)) begin
            errors++; $display("FAIL b2b_we[%0d] got %0d exp %0d", k, we_count - w0, dirty); end
         if (m1) begin
            checks++; if (mif.gpr_out1 !== g1) begin errors++; $display("FAIL b2b_gpr1[%0d] got %h exp %h", k, mif.gpr_out1, g1); end
         end
         if (m2) begin
            checks++; if (mif.gpr_out2 !== g2) begin errors++; $display("FAIL b2b_gpr2[%0d] got %h exp %h", k, mif.gpr_out2, g2); end
         end
      end
   endtask

   task automatic test_reset_run2();
      drive(1, OP_MULT, 1, 32'd7, 32'd8, 1, OP_MUL, 1, 32'd3, 32'd3, 64'd5);
      wait_state(S_RUN2, "rst_run2");
      rst = 0; mif.req1 = 0; mif.req2 = 0;
      #1;
      checks++; if ({mif.unit_mul_start, mif.unit_div_start, mif.unit_sign, mif.md_stall, mif.hilo_we} !== 5'd0) begin
         errors++; $display("FAIL rst_run2_ctrl got %b exp 00000",
            {mif.unit_mul_start, mif.unit_div_start, mif.unit_sign, mif.md_stall, mif.hilo_we}); end
      checks++; if ({mif.unit_a, mif.unit_b} !== 64'd0) begin errors++; $display("FAIL rst_run2_operands got %h exp 0", {mif.unit_a, mif.unit_b}); end
      checks++; if ({mif.gpr_out1, mif.gpr_out2} !== 64'd0) begin errors++; $display("FAIL rst_run2_gpr got %h exp 0", {mif.gpr_out1, mif.gpr_out2}); end
      checks++; if (mif.hilo_wdata !== 64'd0 || mif.dbg_state !== S_IDLE) begin
         errors++; $display("FAIL rst_run2_state got %h/%0d exp 0/0", mif.hilo_wdata, mif.dbg_state); end
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mult_single();
      test_div_mul();
      test_madd_fwd();
      test_stall_done();
      test_flush();
      test_msub_exc();
      test_back_to_back();
      test_reset_run2();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
